pipelined_cs_subtractor: RTL and testbench

- Two-stage pipelined carry-select subtractor computing diff = a - b on WIDTH-bit operands.
- Serves as the arithmetic counterpart to the team's single-cycle carry-select adder. It reuses the same split-half, precompute-both-candidates structure, but runs in the subtract direction and adds a valid/ready stream interface.
- Used where a subtract path must close timing at full clock rate and tolerate downstream backpressure.

---
 rtl/pipelined_cs_subtractor_pkg.sv | 32 +++
 rtl/pipelined_cs_subtractor_if.sv | 27 ++
 rtl/pipelined_cs_subtractor_adder.sv | 17 +
 rtl/pipelined_cs_subtractor.sv | 103 ++++++++++
 tb/tb_pipelined_cs_subtractor.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_cs_subtractor_pkg.sv
// Shared types and constants for the pipelined carry-select subtractor.
//   CSUB_WIDTH : default operand/result width
//   CSUB_HALF  : split point between the low and high halves
//   s1_t       : stage-1 register payload (low result + both high candidates)
//   res_t      : stage-2 result payload (diff, borrow, overflow)
package csub_pkg;

    localparam int unsigned CSUB_WIDTH = 32;

    // Split point for a WIDTH-bit operand; WIDTH must be even and >= 4.
    function automatic int unsigned half_of(input int unsigned width);
        return width / 2;
    endfunction

    localparam int unsigned CSUB_HALF = half_of(CSUB_WIDTH);

    typedef struct packed {
        logic [CSUB_HALF-1:0] lo_diff;
        logic                 lo_carry;
        logic [CSUB_HALF:0]   hi0;      // high half assuming no carry-in
        logic [CSUB_HALF:0]   hi1;      // high half assuming carry-in
        logic                 a_msb;
        logic                 b_msb;
    } s1_t;

    typedef struct packed {
        logic [CSUB_WIDTH-1:0] diff;
        logic                  borrow;
        logic                  overflow;
    } res_t;

endpackage

// File: rtl/pipelined_cs_subtractor_if.sv
// Valid/ready stream bus for the pipelined carry-select subtractor.
//   in_valid/in_ready/a/b                       : operand stream into the block
//   out_valid/out_ready/diff/borrow/overflow    : result stream out of the block
// master = producer/consumer around the block, slave = the subtractor itself.
interface pipelined_cs_subtractor_if #(
    parameter int unsigned WIDTH = csub_pkg::CSUB_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/pipelined_cs_subtractor_adder.sv
// Plain W-bit adder with carry-in/carry-out; one building block of the
// carry-select structure.
//   a_i, b_i : W-bit addends
//   cin_i    : carry in
//   sum_o    : W-bit sum
//   cout_o   : carry out
module half_width_adder #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    assign {cout_o, sum_o} = (W+1)'(a_i) + (W+1)'(b_i) + (W+1)'(cin_i);
endmodule

// File: rtl/pipelined_cs_subtractor.sv
// Two-stage pipelined carry-select subtractor: diff = a - b, computed as
// a + ~b + 1. Stage 1 registers the low-half result and both high-half
// candidates; stage 2 selects the candidate using the low-half carry.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of the valid/ready operand/result stream
// WIDTH must equal csub_pkg::CSUB_WIDTH (the payload structs are sized by it).
module pipelined_cs_subtractor
    import csub_pkg::*;
#(
    parameter int unsigned WIDTH = CSUB_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_cs_subtractor_if.slave  bus
);
    localparam int unsigned HALF = half_of(WIDTH);

    logic [HALF-1:0] a_lo, a_hi, nb_lo, nb_hi;
    logic [HALF-1:0] lo_sum, h0_sum, h1_sum;
    logic            lo_cout, h0_cout, h1_cout;

    s1_t  s1_q, s1_d;
    res_t res_q, res_d;
    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv;
    logic [HALF:0] hi_sel;

    // Operand split; subtrahend inverted so the adders form a + ~b + cin.
    assign a_lo  = bus.a[HALF-1:0];
    assign a_hi  = bus.a[WIDTH-1:HALF];
    assign nb_lo = ~bus.b[HALF-1:0];
    assign nb_hi = ~bus.b[WIDTH-1:HALF];

    half_width_adder #(.W(HALF)) u_lo (
        .a_i(a_lo), .b_i(nb_lo), .cin_i(1'b1), .sum_o(lo_sum), .cout_o(lo_cout)
    );

    half_width_adder #(.W(HALF)) u_hi0 (
        .a_i(a_hi), .b_i(nb_hi), .cin_i(1'b0), .sum_o(h0_sum), .cout_o(h0_cout)
    );

    half_width_adder #(.W(HALF)) u_hi1 (
        .a_i(a_hi), .b_i(nb_hi), .cin_i(1'b1), .sum_o(h1_sum), .cout_o(h1_cout)
    );

    // Handshake: each stage advances when it is empty or its successor advances.
    always_comb begin
        s2_adv = !s2_valid_q || bus.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign bus.in_ready = s1_adv;

    // Stage-1 payload.
    always_comb begin
        s1_d          = '0;
        s1_d.lo_diff  = lo_sum;
        s1_d.lo_carry = lo_cout;
        s1_d.hi0      = {h0_cout, h0_sum};
        s1_d.hi1      = {h1_cout, h1_sum};
        s1_d.a_msb    = bus.a[WIDTH-1];
        s1_d.b_msb    = bus.b[WIDTH-1];
    end

    // Carry-select: the low-half carry only picks a candidate, never ripples.
    always_comb begin
        res_d          = '0;
        hi_sel         = s1_q.lo_carry ? s1_q.hi1 : s1_q.hi0;
        res_d.diff     = {hi_sel[HALF-1:0], s1_q.lo_diff};
        res_d.borrow   = ~hi_sel[HALF];
        res_d.overflow = (s1_q.a_msb != s1_q.b_msb) && (hi_sel[HALF-1] != s1_q.a_msb);
    end

    // Pipeline registers; a stalled stage holds data and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            res_q      <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                end
            end
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= s1_d;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.diff      = res_q.diff;
    assign bus.borrow    = res_q.borrow;
    assign bus.overflow  = res_q.overflow;

endmodule

// File: tb/tb_pipelined_cs_subtractor.sv
// Self-checking bench for pipelined_cs_subtractor (WIDTH = 32).
module tb_pipelined_cs_subtractor;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_cs_subtractor_if #(.WIDTH(W)) bus ();

    pipelined_cs_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {diff, borrow, overflow}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return {d, (a < b), ((a[W-1] != b[W-1]) && (d[W-1] != a[W-1]))};
    endfunction

    function automatic logic [W+1:0] dut_res();
        return {bus.diff, bus.borrow, bus.overflow};
    endfunction

    initial begin
        logic [W+1:0] expq[$];
        logic [W+1:0] exp_v;
        logic [W-1:0] bp_a[4];
        logic [W-1:0] bp_b[4];
        logic [W-1:0] bp_got[4];
        int idx, got, sent, bubbles, stalls;

        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1]  = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5]  = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[6]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        vecs[7]  = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(dut_res()), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors, one at a time, 2-cycle latency.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            tick();
            bus.in_valid = 1'b0;
            bus.a        = '0;
            bus.b        = '0;
            tick();
            #1;
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_result", i), 64'(dut_res()),
                64'({vecs[i].d, vecs[i].br, vecs[i].ov}));
        end
        tick();
        tick();

        // Backpressure: out_ready low for 5 cycles with 4 inputs pending.
        bp_a = '{32'd10, 32'd20, 32'd30, 32'd40};
        bp_b = '{32'd1, 32'd2, 32'd3, 32'd4};
        idx  = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (idx < 4);
            bus.a        = bp_a[idx % 4];
            bus.b        = bp_b[idx % 4];
            #1;
            chk($sformatf("bp_in_ready_c%0d", c), 64'(bus.in_ready), (c < 2) ? 64'd1 : 64'd0);
            if (c >= 2) begin
                chk($sformatf("bp_hold_valid_c%0d", c), 64'(bus.out_valid), 64'd1);
                chk($sformatf("bp_hold_diff_c%0d", c), 64'(bus.diff), 64'd9);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            bus.in_valid = (idx < 4);
            bus.a        = bp_a[idx % 4];
            bus.b        = bp_b[idx % 4];
            #1;
            if (bus.out_valid && bus.out_ready) begin
                bp_got[got] = bus.diff;
                got++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 64'(got), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got) chk($sformatf("bp_order%0d", i), 64'(bp_got[i]), 64'((i + 1) * 9));
        end
        tick();
        tick();
        chk("bp_no_dup", 64'(bus.out_valid), 64'd0);

        // Full-rate stream of random operands.
        expq.delete();
        got = 0; sent = 0; bubbles = 0; stalls = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 120 && got < 100; c++) begin
            if (sent < 100) begin
                bus.in_valid = 1'b1;
                bus.a        = $urandom;
                bus.b        = $urandom;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (sent < 100 && !bus.in_ready) stalls++;
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk("stream_unexpected", 64'(dut_res()), 64'd0);
                end else begin
                    exp_v = expq.pop_front();
                    chk($sformatf("stream%0d", got), 64'(dut_res()), 64'(exp_v));
                end
                got++;
            end else if (c >= 2) begin
                bubbles++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model(bus.a, bus.b));
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("stream_count", 64'(got), 64'd100);
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        chk("stream_stalls", 64'(stalls), 64'd0);
        tick();
        tick();

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'h0000_0064 + 32'(c);
            bus.b        = 32'h0000_0001;
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        chk("mid_full_valid", 64'(bus.out_valid), 64'd1);
        chk("mid_full_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_diff", 64'(bus.diff), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.out_valid) got++;
        end
        chk("mid_rst_discard", 64'(got), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
